// File: rtl/bcd_pkg.sv
// Shared constants for the sequential double-dabble BCD converter.
// State encoding plus the add-3 correction constants.
package bcd_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE   = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;
endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit double-dabble correction: add 3 when the digit is 5 or more.
// Purely combinational, no carry into the neighbouring digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one shift per clock, with start/done
// handshake, leading-zero blank mask and saturating overflow flag.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 20,
  parameter int DIGITS   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);
  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  state_t              r_state, w_state_next;
  logic [IN_WIDTH-1:0] r_shift;
  logic [BW-1:0]       r_bcd;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_cnt;
  logic [BW-1:0]       r_bcd_out;
  logic [DIGITS-1:0]   r_blank;
  logic                r_overflow;

  logic [BW-1:0]       w_bcd_adj;
  logic [BW-1:0]       w_bcd_shifted;
  logic [BW-1:0]       w_bcd_final;
  logic                w_ovf_next;
  logic                w_last;
  logic                w_accept;
  logic [DIGITS:1]     w_hi_zero;
  logic [DIGITS-1:0]   w_blank;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_bcd[4*gi +: 4]),
        .o_digit (w_bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // The bit leaving the top digit means the value no longer fits.
  assign w_ovf_next    = r_ovf | w_bcd_adj[BW-1];
  assign w_bcd_shifted = {w_bcd_adj[BW-2:0], r_shift[IN_WIDTH-1]};
  assign w_bcd_final   = w_ovf_next ? {DIGITS{BCD_NINE}} : w_bcd_shifted;
  assign w_last        = (r_cnt == CNT_W'(1));
  assign w_accept      = start && (r_state != ST_SHIFT);

  // Saturated all-9s result has no zero digits, so overflow never blanks.
  assign w_hi_zero[DIGITS] = 1'b1;
  assign w_blank[0]        = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign w_hi_zero[gi] = w_hi_zero[gi+1] & (w_bcd_final[4*gi +: 4] == 4'd0);
      assign w_blank[gi]   = w_hi_zero[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last)   w_state_next = ST_DONE;
      ST_DONE:  w_state_next = w_accept ? ST_SHIFT : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_SHIFT);
    done = (r_state == ST_DONE);
  end

  // Results are registered on the final shift so they are valid with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_bcd_out  <= '0;
      r_blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
      r_overflow <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_shift <= r_shift << 1;
      r_bcd   <= w_bcd_shifted;
      r_ovf   <= w_ovf_next;
      r_cnt   <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_bcd_out  <= w_bcd_final;
        r_blank    <= w_blank;
        r_overflow <= w_ovf_next;
      end
    end else if (w_accept) begin
      r_shift <= bin_in;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= CNT_W'(IN_WIDTH);
    end
  end

  assign bcd_out  = r_bcd_out;
  assign blank    = r_blank;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, random values against
// a decimal reference model, handshake/reset sequences and a small-width sweep.
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] bin_in;
  logic        busy, done, overflow;
  logic [23:0] bcd_out;
  logic [5:0]  blank;

  logic        s_start;
  logic [3:0]  s_bin;
  logic        s_busy, s_done, s_overflow;
  logic [7:0]  s_bcd;
  logic [1:0]  s_blank;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.IN_WIDTH(20), .DIGITS(6)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank), .overflow(overflow)
  );

  bin2bcd_seq #(.IN_WIDTH(4), .DIGITS(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .bin_in(s_bin),
    .busy(s_busy), .done(s_done), .bcd_out(s_bcd), .blank(s_blank), .overflow(s_overflow)
  );

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [5:0]  blk;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digits from division, saturate above 10^d - 1.
  function automatic void ref_model(input longint unsigned v, input int d,
                                    output logic [31:0] bcd, output logic [7:0] blk,
                                    output logic ovf);
    longint unsigned lim;
    longint unsigned t;
    int nd;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    bcd = '0;
    blk = '0;
    ovf = 1'b0;
    if (v >= lim) begin
      ovf = 1'b1;
      for (int i = 0; i < d; i++) bcd[4*i +: 4] = 4'd9;
    end else begin
      t = v;
      for (int i = 0; i < d; i++) begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      nd = 1;
      t = v / 10;
      while (t != 0) begin
        nd++;
        t = t / 10;
      end
      for (int i = 1; i < d; i++) blk[i] = (i >= nd);
    end
  endfunction

  // Starts a conversion on the main DUT and checks latency and results.
  task automatic run_main(input logic [19:0] v, input logic [23:0] eb,
                          input logic [5:0] ebl, input logic eo);
    int c;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    c = 0;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("latency", c, 20);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("bcd_out", 32'(bcd_out), 32'(eb));
    chk("blank", 32'(blank), 32'(ebl));
    chk("overflow", 32'(overflow), 32'(eo));
    $display("conv %0d -> bcd %06h blank %06b ovf %0d (%0d cycles)", v, bcd_out, blank, overflow, c + 1);
  endtask

  task automatic run_small(input logic [3:0] v);
    int c;
    logic [31:0] eb;
    logic [7:0]  ebl;
    logic        eo;
    ref_model(longint'(v), 2, eb, ebl, eo);
    @(negedge clk);
    s_start = 1'b1;
    s_bin   = v;
    @(negedge clk);
    s_start = 1'b0;
    c = 0;
    while (!s_done && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("small_latency", c, 4);
    chk("small_bcd", 32'(s_bcd), 32'(eb[7:0]));
    chk("small_blank", 32'(s_blank), 32'(ebl[1:0]));
    chk("small_ovf", 32'(s_overflow), 32'(eo));
    $display("small %0d -> bcd %02h blank %02b", v, s_bcd, s_blank);
  endtask

  initial begin
    vec_t tbl[9];
    logic [31:0] eb;
    logic [7:0]  ebl;
    logic        eo;
    logic [19:0] rv;
    int c;
    int dones;

    tbl[0] = '{20'd0,       24'h000000, 6'b111110, 1'b0};
    tbl[1] = '{20'd123456,  24'h123456, 6'b000000, 1'b0};
    tbl[2] = '{20'd42,      24'h000042, 6'b111100, 1'b0};
    tbl[3] = '{20'd999999,  24'h999999, 6'b000000, 1'b0};
    tbl[4] = '{20'd1000000, 24'h999999, 6'b000000, 1'b1};
    tbl[5] = '{20'd1048575, 24'h999999, 6'b000000, 1'b1};
    tbl[6] = '{20'd7,       24'h000007, 6'b111110, 1'b0};
    tbl[7] = '{20'd10,      24'h000010, 6'b111100, 1'b0};
    tbl[8] = '{20'd100000,  24'h100000, 6'b000000, 1'b0};

    reset = 1'b1; start = 1'b0; bin_in = '0; s_start = 1'b0; s_bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_blank", 32'(blank), 32'b111110);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) run_main(tbl[i].bin, tbl[i].bcd, tbl[i].blk, tbl[i].ovf);

    for (int i = 0; i < 25; i++) begin
      rv = (i % 3 == 0) ? 20'(999990 + $urandom_range(0, 20)) : 20'($urandom_range(0, 20'hFFFFF));
      ref_model(longint'(rv), 6, eb, ebl, eo);
      run_main(rv, eb[23:0], ebl[5:0], eo);
    end

    // Starts while busy are ignored; bin_in changes while busy are ignored.
    @(negedge clk);
    start = 1'b1; bin_in = 20'd777;
    @(negedge clk);
    c = 0;
    while (!done && c < 100) begin
      start  = (c == 4 || c == 9);
      bin_in = 20'd123;
      @(negedge clk);
      c++;
    end
    chk("hs_latency", c, 20);
    chk("hs_bcd", 32'(bcd_out), 32'h000777);
    $display("handshake 777 -> bcd %06h", bcd_out);
    // Start held during the done cycle is accepted immediately.
    start = 1'b1; bin_in = 20'd31;
    @(negedge clk);
    start = 1'b0;
    chk("hs_done_pulse", 32'(done), 32'd0);
    chk("hs_b2b_busy", 32'(busy), 32'd1);
    c = 1;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_period", c, 21);
    chk("b2b_bcd", 32'(bcd_out), 32'h000031);
    $display("back-to-back 31 -> bcd %06h after %0d cycles", bcd_out, c);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; bin_in = 20'd555555;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_blank", 32'(blank), 32'b111110);
    chk("abort_ovf", 32'(overflow), 32'd0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    $display("abort 555555 -> bcd %06h blank %06b", bcd_out, blank);
    run_main(20'd8, 24'h000008, 6'b111110, 1'b0);

    for (int v = 0; v < 16; v++) run_small(4'(v));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
